sp_ram_arbiter: RTL and testbench
=================================

# sp_ram_arbiter

Two-requester arbiter and sequencer for a 16x8 single-port RAM. After reset it clears the RAM, then round-robins one access per cycle between port A and port B over a req/gnt handshake. Read data is returned to the granted port with a valid strobe. It sits between two datapath masters and the shared storage array, which is instantiated inside the block.

## Interface
Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- DATA_W, 8, word width

Ports:
- clk_in  input  1  single clock; all logic on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- req_a_in / req_b_in  input  1  access request, held until granted
- we_a_in / we_b_in  input  1  1 = write, 0 = read; qualified by req
- addr_a_in / addr_b_in  input  ADDR_W  word address
- wdata_a_in / wdata_b_in  input  DATA_W  write data
- gnt_a_out / gnt_b_out  output  1  combinational accept pulse; access happens at this edge
- rvalid_a_out / rvalid_b_out  output  1  registered; read data valid, one cycle
- rdata_a_out / rdata_b_out  output  DATA_W  registered read data; holds its last value
- init_done_out  output  1  registered; high once the RAM clear has completed

## Operation
- FSM states:
  - INIT: entered on reset. A 4-bit clear counter writes 0 to addresses 0..DEPTH-1, one per cycle. Both gnt outputs are forced low; requests wait. After address DEPTH-1 is written, go to RUN.
  - RUN: arbitrate every cycle.
- Round-robin pointer prio (0 = A first, 1 = B first):
  - Both requesting: grant the prioritised side, then set prio to point at the other side.
  - One requesting: grant it. prio is set to point at the non-granted side.
  - No request: prio unchanged.
- At most one gnt is high per cycle; exactly one RAM operation per grant.
- Write: RAM[addr] <= wdata at the grant edge. No rvalid.
- Read: RAM is read at the grant edge. rdata_x and rvalid_x are registered the next cycle; only the granted side's rdata updates.
- Same-cycle ordering: a read granted in the cycle after a write to the same address returns the new data.
- Reset values:
  - state = INIT, clear counter = 0, prio = 0
  - gnt_* = 0 (combinational, low throughout INIT)
  - rvalid_* = 0, rdata_* = 0, init_done_out = 0
- RAM contents are not reset directly; the INIT sweep defines them.
- Reset mid-operation: the FSM returns to INIT and the clear restarts from address 0. A pending rvalid is dropped. Requesters must re-issue.
- Out-of-range addresses cannot occur because the address is exactly ADDR_W bits.

## Timing
- INIT lasts exactly DEPTH cycles, 16 at defaults.
- init_done_out rises on the edge that leaves INIT and stays high until the next reset.
- Grant latency: 0 cycles. gnt_x is high in the same cycle as req_x if x wins.
- Requester drops req (or presents its next request) after the edge where gnt was high.
- Read latency: rvalid_x is high in the cycle after gnt_x.
- Throughput: one access per cycle. Sustained dual requests alternate A,B,A,B.
- A single requester with continuous req is granted every cycle.
- No combinational path from rdata to any output.

## Structure
- Shared package sp_ram_pkg:
  - ADDR_W / DATA_W defaults
  - FSM state typedef (INIT, RUN)
  - port-select constants PORT_A = 0, PORT_B = 1
- Sub-module sp_ram_core is the DEPTH x DATA_W synchronous single-port array.
  - Ports: clk_in, en_in, we_in, addr_in, wdata_in, rdata_out.
  - rdata is registered, with 1-cycle latency.
- The top block holds the FSM, clear counter, prio register, request mux and response demux.

## Test plan
- Reset release with requests held: gnt_* stays 0 for 16 cycles and init_done_out rises at cycle 16. A read of each address 0..15 then returns 0x00.
- A writes addr 3 = 0xA5, then reads addr 3: gnt_a is high on both cycles, rvalid_a is high 1 cycle after the read grant, and rdata_a = 0xA5. Port B outputs stay idle.
- A and B request continuously (A reads addr 1, B reads addr 2, preloaded 0x11/0x22) for 6 cycles: grants go A,B,A,B,A,B and the rdata values alternate 0x11/0x22 on the matching port.
- Both request in the same cycle with prio = 1 (B): B is granted first, then A next cycle. No cycle has both gnt high.
- A writes addr 7 = 0x3C, and B reads addr 7 in the very next cycle: rdata_b = 0x3C.
- Assert rst_n_in in RUN with a read in flight: rvalid is never pulsed, init_done_out drops immediately, and the 16-cycle clear repeats. A previously written addr 3 then reads 0x00.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// Shared definitions for the two-port arbiter in front of a single-port RAM.
// Holds the default geometry, the sequencer states and the port-select encoding.
package sp_ram_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sp_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sp_ram_core.sv
// DEPTH x DATA_W synchronous single-port storage array.
// One operation per enabled edge; read data is registered with one cycle of latency.
module sp_ram_core
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_in,
    input  logic              en_in,
    input  logic              we_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic [DATA_W-1:0] rdata_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array: contents are defined by the clear sweep in the parent.
    always_ff @(posedge clk_in) begin
        if (en_in) begin
            if (we_in) begin
                mem[addr_in] <= wdata_in;
            end else begin
                rdata_out <= mem[addr_in];
            end
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port RAM between ports A and B.
// After reset the RAM is swept to zero, then one access per cycle is granted.
module sp_ram_arbiter
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req_a_in,
    input  logic              we_a_in,
    input  logic [ADDR_W-1:0] addr_a_in,
    input  logic [DATA_W-1:0] wdata_a_in,
    input  logic              req_b_in,
    input  logic              we_b_in,
    input  logic [ADDR_W-1:0] addr_b_in,
    input  logic [DATA_W-1:0] wdata_b_in,
    output logic              gnt_a_out,
    output logic              gnt_b_out,
    output logic              rvalid_a_out,
    output logic              rvalid_b_out,
    output logic [DATA_W-1:0] rdata_a_out,
    output logic [DATA_W-1:0] rdata_b_out,
    output logic              init_done_out,
    output sp_state_t         fsm_state
);

    // Handshake: a requester raises req with we/addr/wdata stable and holds them
    // until it sees gnt high. The access takes place on the rising edge that ends
    // the gnt cycle; a read returns rdata with a one-cycle rvalid strobe after it.

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    sp_state_t         state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              prio;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;
    logic              run;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign run       = (state == RUN);
    assign fsm_state = state;

    always_comb begin
        gnt_a_out = run && req_a_in && (!req_b_in || prio == PORT_A);
        gnt_b_out = run && req_b_in && (!req_a_in || prio == PORT_B);
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!run) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_cnt;
        end else if (gnt_a_out) begin
            ram_en    = 1'b1;
            ram_we    = we_a_in;
            ram_addr  = addr_a_in;
            ram_wdata = wdata_a_in;
        end else if (gnt_b_out) begin
            ram_en    = 1'b1;
            ram_we    = we_b_in;
            ram_addr  = addr_b_in;
            ram_wdata = wdata_b_in;
        end
    end

    sp_ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk_in    (clk_in),
        .en_in     (ram_en),
        .we_in     (ram_we),
        .addr_in   (ram_addr),
        .wdata_in  (ram_wdata),
        .rdata_out (ram_rdata)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= INIT;
            clr_cnt       <= '0;
            prio          <= PORT_A;
            init_done_out <= 1'b0;
            rvalid_a_out  <= 1'b0;
            rvalid_b_out  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state         <= RUN;
                        init_done_out <= 1'b1;
                    end
                end
                RUN: begin
                    if (gnt_a_out) begin
                        prio <= PORT_B;
                    end else if (gnt_b_out) begin
                        prio <= PORT_A;
                    end
                end
            endcase
            rvalid_a_out <= gnt_a_out && !we_a_in;
            rvalid_b_out <= gnt_b_out && !we_b_in;
        end
    end

    // The core's output register is shared by both ports, so each port keeps a
    // copy of its last read word; only the port whose rvalid is up follows the core.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            if (rvalid_a_out) begin
                hold_a <= ram_rdata;
            end
            if (rvalid_b_out) begin
                hold_b <= ram_rdata;
            end
        end
    end

    assign rdata_a_out = rvalid_a_out ? ram_rdata : hold_a;
    assign rdata_b_out = rvalid_b_out ? ram_rdata : hold_b;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed scenarios plus randomized two-port traffic,
// checked cycle by cycle against a behavioural model through expected queues.
`timescale 1ns/1ps
module tb_sp_ram_arbiter;
    import sp_ram_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req_a, we_a, req_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
    logic [DW-1:0] rdata_a, rdata_b;
    sp_state_t     fsm_state;

    sp_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_a_in      (req_a),
        .we_a_in       (we_a),
        .addr_a_in     (addr_a),
        .wdata_a_in    (wdata_a),
        .req_b_in      (req_b),
        .we_b_in       (we_b),
        .addr_b_in     (addr_b),
        .wdata_b_in    (wdata_b),
        .gnt_a_out     (gnt_a),
        .gnt_b_out     (gnt_b),
        .rvalid_a_out  (rvalid_a),
        .rvalid_b_out  (rvalid_b),
        .rdata_a_out   (rdata_a),
        .rdata_b_out   (rdata_b),
        .init_done_out (init_done),
        .fsm_state     (fsm_state)
    );

    // scoreboard state
    typedef struct {
        logic ga;
        logic gb;
        logic rva;
        logic rvb;
        logic done;
    } cyc_t;

    cyc_t          rec_q[$];
    logic [DW-1:0] exp_qa[$];
    logic [DW-1:0] exp_qb[$];
    logic [DW-1:0] seen_a = '0;
    logic [DW-1:0] seen_b = '0;
    logic          mon_en = 1'b0;
    int            checks = 0;
    int            errors = 0;

    // reference model: RAM image, whose turn it is, remaining clear cycles
    logic [DW-1:0] model_mem [DEPTH];
    int            next_turn;   // 0: A wins a tie, 1: B wins a tie
    int            init_left;
    logic          last_rd_a, last_rd_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        next_turn = 0;
        init_left = DEPTH;
        last_rd_a = 1'b0;
        last_rd_b = 1'b0;
        exp_qa.delete();
        exp_qb.delete();
        rec_q.delete();
        seen_a = '0;
        seen_b = '0;
    endtask

    // driver: called at posedge+1, applies one cycle of requests, predicts it,
    // then advances to the next posedge+1
    task automatic cycle(input logic ra, input logic wa, input logic [AW-1:0] aa,
                         input logic [DW-1:0] da,
                         input logic rb, input logic wb, input logic [AW-1:0] ab,
                         input logic [DW-1:0] db,
                         output logic ga, output logic gb);
        cyc_t r;
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        r.rva  = last_rd_a;
        r.rvb  = last_rd_b;
        r.done = (init_left == 0);
        ga = 1'b0;
        gb = 1'b0;
        if (init_left > 0) begin
            init_left--;
        end else if (ra && rb) begin
            if (next_turn == 0) ga = 1'b1;
            else gb = 1'b1;
        end else begin
            ga = ra;
            gb = rb;
        end
        if (ga) begin
            next_turn = 1;
            if (wa) model_mem[aa] = da;
            else exp_qa.push_back(model_mem[aa]);
        end
        if (gb) begin
            next_turn = 0;
            if (wb) model_mem[ab] = db;
            else exp_qb.push_back(model_mem[ab]);
        end
        last_rd_a = ga && !wa;
        last_rd_b = gb && !wb;
        r.ga = ga;
        r.gb = gb;
        rec_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic ga, gb;
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0, ga, gb);
    endtask

    // single-port request held until the model grants it
    task automatic issue(input int port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
        logic ga, gb, done;
        int   n;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            if (port == 0) cycle(1, we, addr, data, 0, 0, '0, '0, ga, gb);
            else           cycle(0, 0, '0, '0, 1, we, addr, data, ga, gb);
            done = (port == 0) ? ga : gb;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: port %0d addr %0d not granted within 40 cycles", port, addr);
        end
    endtask

    // monitor: compares DUT outputs to the expectation of each cycle
    initial begin : monitor
        cyc_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rec_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rec_q: no expectation queued at %0t", $time);
                end else begin
                    r = rec_q.pop_front();
                    chk("gnt_a", 32'(gnt_a), 32'(r.ga));
                    chk("gnt_b", 32'(gnt_b), 32'(r.gb));
                    chk("rvalid_a", 32'(rvalid_a), 32'(r.rva));
                    chk("rvalid_b", 32'(rvalid_b), 32'(r.rvb));
                    chk("init_done", 32'(init_done), 32'(r.done));
                    if (rvalid_a === 1'b1) begin
                        if (exp_qa.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL rdata_a: unexpected rvalid_a, got 0x%0h expected none", rdata_a);
                        end else begin
                            seen_a = exp_qa.pop_front();
                            chk("rdata_a", 32'(rdata_a), 32'(seen_a));
                        end
                    end else begin
                        chk("rdata_a_hold", 32'(rdata_a), 32'(seen_a));
                    end
                    if (rvalid_b === 1'b1) begin
                        if (exp_qb.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL rdata_b: unexpected rvalid_b, got 0x%0h expected none", rdata_b);
                        end else begin
                            seen_b = exp_qb.pop_front();
                            chk("rdata_b", 32'(rdata_b), 32'(seen_b));
                        end
                    end else begin
                        chk("rdata_b_hold", 32'(rdata_b), 32'(seen_b));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic          ga, gb, pa, pb, wa, wb;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] da, db;

        // reset with port A request already held
        rst_n = 1'b0;
        req_a = 1'b1; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt_a", 32'(gnt_a), 32'd0);
        chk("reset_init_done", 32'(init_done), 32'd0);
        chk("reset_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("reset_rdata_a", 32'(rdata_a), 32'd0);
        chk("reset_rdata_b", 32'(rdata_b), 32'd0);
        chk("reset_state", 32'(fsm_state), 32'(INIT));

        model_reset();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        issue(0, 0, 4'd0, '0);
        for (int i = 0; i < DEPTH; i++) issue(i % 2, 0, AW'(i), '0);
        idle(2);

        // write then read on A
        issue(0, 1, 4'd3, 8'hA5);
        issue(0, 0, 4'd3, '0);
        idle(2);

        // preload and sustained dual reads
        issue(0, 1, 4'd1, 8'h11);
        issue(1, 1, 4'd2, 8'h22);
        for (int i = 0; i < 6; i++) cycle(1, 0, 4'd1, '0, 1, 0, 4'd2, '0, ga, gb);
        idle(2);

        // tie while B holds priority
        issue(0, 1, 4'd5, 8'h5A);
        cycle(1, 0, 4'd5, '0, 1, 0, 4'd3, '0, ga, gb);
        cycle(1, 0, 4'd5, '0, 0, 0, '0, '0, ga, gb);
        idle(2);

        // write on A followed immediately by read on B of the same word
        issue(0, 1, 4'd7, 8'h3C);
        issue(1, 0, 4'd7, '0);
        idle(2);

        // reset while a read is being granted
        mon_en = 1'b0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 4'd3; req_b = 1'b0;
        #2;
        chk("pre_reset_gnt_a", 32'(gnt_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_gnt_a", 32'(gnt_a), 32'd0);
        chk("mid_reset_init_done", 32'(init_done), 32'd0);
        chk("mid_reset_state", 32'(fsm_state), 32'(INIT));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("mid_reset_rvalid_a", 32'(rvalid_a), 32'd0);
        end
        model_reset();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        issue(0, 0, 4'd3, '0);
        idle(2);

        // randomized traffic with held requests
        pa = 1'b0; pb = 1'b0;
        wa = 1'b0; wb = 1'b0; aa = '0; ab = '0; da = '0; db = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && $urandom_range(0, 99) < 65) begin
                pa = 1'b1;
                wa = 1'($urandom_range(0, 1));
                aa = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
                da = DW'($urandom_range(0, 255));
            end
            if (!pb && $urandom_range(0, 99) < 65) begin
                pb = 1'b1;
                wb = 1'($urandom_range(0, 1));
                ab = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
                db = DW'($urandom_range(0, 255));
            end
            cycle(pa, wa, aa, da, pb, wb, ab, db, ga, gb);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
        idle(3);
        mon_en = 1'b0;
        chk("leftover_reads_a", 32'(exp_qa.size()), 32'd0);
        chk("leftover_reads_b", 32'(exp_qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
